// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline stall/flush controller.
//   - Merges per-stage stall requests into a priority-encoded 6-bit stall vector.
//   - Remembers a taken branch resolved while IF is held, so that the wrong-path
//     fetch is squashed exactly once, when IF next advances.
//   - Stall watchdog with a sticky error flag.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stalled-cycle and flush
// counters. When it is undefined, both counter outputs are tied to zero.
module pipe_ctrl #(
  parameter int WDOG_W     = 8,
  parameter int WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_flag_i,
  output logic [5:0]  stall_o,
  output logic        flush_if_o,
  output logic        branch_pend_o,
  output logic        wdog_err_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [WDOG_W-1:0] LIMIT_C = WDOG_W'(WDOG_LIMIT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
  logic              stall_any;
  logic              branch_acc;

  // Priority encoder: the deepest requesting stage wins. WB is never stopped here.
  always_comb begin
    stall_o = 6'b000000;
    if (rst) begin
      stall_o = 6'b000000;
    end else if (stallreq_mem_i) begin
      stall_o = 6'b011111;
    end else if (stallreq_ex_i) begin
      stall_o = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_o = 6'b000111;
    end else if (stallreq_if_i) begin
      stall_o = 6'b000011;
    end
  end

  assign stall_any = |stall_o;

  // A branch only counts when ID advances. Otherwise ID sees it again next cycle.
  assign branch_acc = branch_flag_i & ~stall_o[2];

  // Next-state and flush logic. A flush is emitted only in a cycle where IF advances.
  always_comb begin
    state_d    = state_q;
    flush_if_o = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (branch_acc) begin
          if (stall_o[1]) begin
            state_d = ST_PEND;
          end else begin
            flush_if_o = 1'b1;
          end
        end
      end
      ST_PEND: begin
        // A newer branch while pending needs no extra pulse. pc_reg holds the target.
        if (!stall_o[1]) begin
          flush_if_o = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      flush_if_o = 1'b0;
      state_d    = ST_RUN;
    end
  end

  // Watchdog: count consecutive stalled cycles, saturate, and latch the error.
  always_comb begin
    wdog_cnt_d = '0;
    wdog_err_d = wdog_err_q;
    if (stall_any) begin
      if (wdog_cnt_q >= LIMIT_C) begin
        wdog_cnt_d = LIMIT_C;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
      if (wdog_cnt_d == LIMIT_C) begin
        wdog_err_d = 1'b1;
      end
    end
  end

  // State, watchdog counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign branch_pend_o = (state_q == ST_PEND);
  assign wdog_err_o    = wdog_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_cnt_q;

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (stall_any) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_if_o) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_cnt_o    = flush_cnt_q;
`else
  assign stall_cycles_o = 32'h0;
  assign flush_cnt_o    = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        branch_flag_i;
  logic [5:0]  stall_o;
  logic        flush_if_o, branch_pend_o, wdog_err_o;
  logic [31:0] stall_cycles_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.WDOG_W(8), .WDOG_LIMIT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if_i (stallreq_if_i),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .branch_flag_i (branch_flag_i),
    .stall_o       (stall_o),
    .flush_if_o    (flush_if_o),
    .branch_pend_o (branch_pend_o),
    .wdog_err_o    (wdog_err_o),
    .stall_cycles_o(stall_cycles_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Expected counter value: real value with the perf build, zero otherwise.
  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Apply inputs (if, id, ex, mem, branch) and let combinational outputs settle.
  task automatic drive(input logic i_if, input logic i_id, input logic i_ex,
                       input logic i_mem, input logic br);
    stallreq_if_i  = i_if;
    stallreq_id_i  = i_id;
    stallreq_ex_i  = i_ex;
    stallreq_mem_i = i_mem;
    branch_flag_i  = br;
    #1;
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 1, 1, 1, 1);
    check("rst_stall_forced", {26'd0, stall_o}, 32'h0);
    check("rst_flush_forced", {31'd0, flush_if_o}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("rst_pend", {31'd0, branch_pend_o}, 32'h0);
    check("rst_wdog", {31'd0, wdog_err_o}, 32'h0);
    check("rst_stall_cyc", stall_cycles_o, 32'h0);
    check("rst_flush_cnt", flush_cnt_o, 32'h0);

    // Priority encoding
    drive(1, 1, 1, 1, 0); check("prio_mem",  {26'd0, stall_o}, 32'b011111); tick();
    drive(1, 1, 1, 0, 0); check("prio_ex",   {26'd0, stall_o}, 32'b001111); tick();
    drive(1, 1, 0, 0, 0); check("prio_id",   {26'd0, stall_o}, 32'b000111); tick();
    drive(1, 0, 0, 0, 0); check("prio_if",   {26'd0, stall_o}, 32'b000011); tick();
    drive(0, 0, 0, 0, 0); check("prio_none", {26'd0, stall_o}, 32'b000000);
    check("prio_stall_cyc", stall_cycles_o, perf(32'd4));
    tick();

    // Immediate flush
    drive(0, 0, 0, 0, 1);
    check("imm_flush", {31'd0, flush_if_o}, 32'h1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("imm_flush_off", {31'd0, flush_if_o}, 32'h0);
    check("imm_pend", {31'd0, branch_pend_o}, 32'h0);
    check("imm_flush_cnt", flush_cnt_o, perf(32'd1));

    // Deferred flush
    drive(1, 0, 0, 0, 1);
    check("def_c1_stall", {26'd0, stall_o}, 32'b000011);
    check("def_c1_flush", {31'd0, flush_if_o}, 32'h0);
    check("def_c1_pend", {31'd0, branch_pend_o}, 32'h0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("def_c2_pend", {31'd0, branch_pend_o}, 32'h1);
    check("def_c2_flush", {31'd0, flush_if_o}, 32'h0);
    tick();
    check("def_c3_pend", {31'd0, branch_pend_o}, 32'h1);
    check("def_c3_flush", {31'd0, flush_if_o}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("def_c4_pend", {31'd0, branch_pend_o}, 32'h1);
    check("def_c4_flush", {31'd0, flush_if_o}, 32'h1);
    tick();
    check("def_c5_pend", {31'd0, branch_pend_o}, 32'h0);
    check("def_c5_flush", {31'd0, flush_if_o}, 32'h0);
    check("def_flush_cnt", flush_cnt_o, perf(32'd2));
    check("def_stall_cyc", stall_cycles_o, perf(32'd7));

    // Ignored branch while ID is stalled
    drive(0, 1, 0, 0, 1);
    check("ign_stall", {26'd0, stall_o}, 32'b000111);
    check("ign_flush", {31'd0, flush_if_o}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("ign_pend", {31'd0, branch_pend_o}, 32'h0);
    check("ign_flush_after", {31'd0, flush_if_o}, 32'h0);
    tick();

    // Watchdog: 254 stalled cycles then idle -> no error
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 254; i++) tick();
    check("wd_254", {31'd0, wdog_err_o}, 32'h0);
    drive(0, 0, 0, 0, 0);
    tick();
    check("wd_idle", {31'd0, wdog_err_o}, 32'h0);
    // 255 consecutive stalled cycles -> error on the 255th
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 254; i++) tick();
    check("wd_254b", {31'd0, wdog_err_o}, 32'h0);
    tick();
    check("wd_255", {31'd0, wdog_err_o}, 32'h1);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("wd_sticky", {31'd0, wdog_err_o}, 32'h1);
    check("wd_stall_cyc", stall_cycles_o, perf(32'd517));

    // Second branch while pending: still a single pulse
    drive(1, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 1);
    check("pp_flush_in_pend", {31'd0, flush_if_o}, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("pp_pend", {31'd0, branch_pend_o}, 32'h1);
    check("pp_flush", {31'd0, flush_if_o}, 32'h1);
    tick();
    check("pp_flush_cnt", flush_cnt_o, perf(32'd3));
    check("pp_pend_clear", {31'd0, branch_pend_o}, 32'h0);

    // Reset while pending
    drive(1, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0);
    check("rp_pend", {31'd0, branch_pend_o}, 32'h1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("rp_flush_in_rst", {31'd0, flush_if_o}, 32'h0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("rp_pend_after", {31'd0, branch_pend_o}, 32'h0);
    check("rp_wdog", {31'd0, wdog_err_o}, 32'h0);
    check("rp_stall_cyc", stall_cycles_o, 32'h0);
    check("rp_flush_cnt", flush_cnt_o, 32'h0);
    check("rp_no_flush", {31'd0, flush_if_o}, 32'h0);
    tick();
    check("rp_no_flush_later", {31'd0, flush_if_o}, 32'h0);
    check("rp_flush_cnt_later", flush_cnt_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
